// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// wait-counter sizing and the address legality check.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int unsigned MAX_WAIT_CYCLES = 15;
   localparam int unsigned CNT_W           = 4;
   localparam logic [31:0] ALIGN_MASK      = 32'h0000_0003;

   // A byte address is illegal when it is not word aligned or when any bit
   // above the word-index field is set.
   function automatic logic addr_bad(input logic [31:0] adr, input int unsigned addr_w);
      logic [31:0] high_bits;
      high_bits = adr >> (addr_w + 2);
      return ((adr & ALIGN_MASK) != 32'd0) || (high_bits != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage behind the responder: synchronous write, asynchronous read,
// contents are deliberately not reset.
module dmem_responder_array #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] idx,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx] <= wr_data;
      end
   end

   assign rd_data = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: one word per transaction,
// valid/ready request and response channels, configurable access latency.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_adr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

   state_t            state;
   logic [CNT_W-1:0]  wait_cnt;
   logic              lat_wr;
   logic              lat_err;
   logic [ADDR_W-1:0] lat_idx;
   logic [31:0]       lat_wdata;
   logic [31:0]       arr_rdata;
   logic              commit_edge;
   logic              arr_wr_en;

   // The array is written only on the edge that moves WAIT into RESP, and a
   // reset on that same edge must suppress the write.
   assign commit_edge = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
   assign arr_wr_en   = rst_n && commit_edge && lat_wr && !lat_err;

   dmem_responder_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (arr_wr_en),
      .idx     (lat_idx),
      .wr_data (lat_wdata),
      .rd_data (arr_rdata)
   );

   // Request latch, latency counter and registered response. WAIT always
   // spans WAIT_CYCLES+1 cycles so rsp_valid rises WAIT_CYCLES+1 edges after accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         wait_cnt  <= '0;
         lat_wr    <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  lat_wr    <= req_wr;
                  lat_idx   <= req_adr[ADDR_W+1:2];
                  lat_wdata <= req_wdata;
                  lat_err   <= addr_bad(req_adr, ADDR_W);
                  wait_cnt  <= '0;
                  req_ready <= 1'b0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (commit_edge) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= lat_err;
                  rsp_rdata <= (lat_wr || lat_err) ? 32'd0 : arr_rdata;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_rdata <= 32'd0;
               rsp_err   <= 1'b0;
               wait_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: a word-array reference
// model predicts every response; a second instance covers the zero-wait build.
module tb_dmem_responder;

   localparam int W = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_wr;
   logic [31:0] req_adr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid_z, req_ready_z, req_wr_z;
   logic [31:0] req_adr_z, req_wdata_z;
   logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
   logic [31:0] rsp_rdata_z;

   logic [31:0] model_mem [0:255];
   int          checks;
   int          errors;

   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_adr   (req_adr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_zero (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid_z),
      .req_ready (req_ready_z),
      .req_wr    (req_wr_z),
      .req_adr   (req_adr_z),
      .req_wdata (req_wdata_z),
      .rsp_valid (rsp_valid_z),
      .rsp_ready (rsp_ready_z),
      .rsp_rdata (rsp_rdata_z),
      .rsp_err   (rsp_err_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One full transaction on the WAIT_CYCLES=2 instance; expectations come
   // from the word-array model, which is updated only for legal stores.
   task automatic applyStimulus(input logic wr, input logic [31:0] adr,
                                input logic [31:0] wdata, input int hold);
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          idx;
      int          cnt;
      exp_err   = (adr % 4 != 0) || (adr >= 32'd1024);
      idx       = exp_err ? 0 : int'(adr / 4);
      exp_rdata = (wr || exp_err) ? 32'd0 : model_mem[idx];

      req_valid = 1'b1;
      req_wr    = wr;
      req_adr   = adr;
      req_wdata = wdata;
      cnt = 0;
      while (!req_ready && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      checkOutput("req_ready_idle", 32'(req_ready), 1);
      @(posedge clk); #1;

      req_wr    = 1'($urandom_range(0, 1));
      req_adr   = $urandom;
      req_wdata = $urandom;
      rsp_ready = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      checkOutput("req_ready_busy", 32'(req_ready), 0);

      cnt = 0;
      while (!rsp_valid && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      req_valid = 1'b0;
      checkOutput("rsp_valid", 32'(rsp_valid), 1);
      checkOutput("latency", cnt, W + 1);
      checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
      checkOutput("rsp_rdata", rsp_rdata, exp_rdata);

      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", 32'(rsp_valid), 1);
         checkOutput("hold_rdata", rsp_rdata, exp_rdata);
         checkOutput("hold_err", 32'(rsp_err), 32'(exp_err));
         checkOutput("hold_req_ready", 32'(req_ready), 0);
      end

      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("rsp_done", 32'(rsp_valid), 0);
      checkOutput("req_ready_back", 32'(req_ready), 1);

      if (wr && !exp_err) model_mem[idx] = wdata;
   endtask

   initial begin
      int          cnt;
      int          kind;
      int          idx;
      logic [31:0] adr;
      logic        acc;
      int          accepts[$];
      int          rsps;
      int          last_acc;
      logic [31:0] val;

      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      req_valid   = 1'b0; req_wr   = 1'b0; req_adr   = 32'd0; req_wdata   = 32'd0; rsp_ready   = 1'b0;
      req_valid_z = 1'b0; req_wr_z = 1'b0; req_adr_z = 32'd0; req_wdata_z = 32'd0; rsp_ready_z = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", 32'(req_ready), 1);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 0);
      checkOutput("reset_z_req_ready", 32'(req_ready_z), 1);
      checkOutput("reset_z_rsp_valid", 32'(rsp_valid_z), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 0);

      applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
      applyStimulus(1'b0, 32'h0000_0010, 32'd0, 0);
      checkOutput("directed_lw_0x10", model_mem[4], 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0000_0012, 32'd0, 0);
      applyStimulus(1'b1, 32'h0000_0400, 32'hCAFE_F00D, 0);
      applyStimulus(1'b0, 32'h0000_0000, 32'd0, 0);
      applyStimulus(1'b0, 32'h0000_0010, 32'd0, 5);

      // Store aborted by a reset pulse in the middle of WAIT.
      req_valid = 1'b1; req_wr = 1'b1; req_adr = 32'h0000_0020; req_wdata = 32'h1234_5678;
      cnt = 0;
      while (!req_ready && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("abort_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("abort_req_ready", 32'(req_ready), 1);
      for (int i = 0; i < W + 3; i++) begin
         @(posedge clk); #1;
         checkOutput("abort_no_rsp", 32'(rsp_valid), 0);
      end
      applyStimulus(1'b0, 32'h0000_0020, 32'd0, 0);

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 9);
         idx  = $urandom_range(0, 15);
         if (kind < 7)      adr = 32'(idx * 4);
         else if (kind < 9) adr = 32'(idx * 4) + 32'($urandom_range(1, 3));
         else               adr = $urandom | 32'h0000_0400;
         applyStimulus(1'($urandom_range(0, 1)), adr, $urandom, $urandom_range(0, 3));
      end

      // Zero-wait instance: request and rsp_ready held high, so accepts
      // should land every third edge with the response one edge after each.
      val         = 32'hA5A5_0F0F;
      req_valid_z = 1'b1; req_wr_z = 1'b1; req_adr_z = 32'h0000_0040; req_wdata_z = val;
      rsp_ready_z = 1'b1;
      rsps        = 0;
      for (int c = 0; c < 13; c++) begin
         acc = req_valid_z && req_ready_z;
         @(posedge clk); #1;
         last_acc = (accepts.size() > 0) ? accepts[$] : -100;
         if (acc) begin
            if (accepts.size() > 0) checkOutput("z_spacing", c - last_acc, 3);
            accepts.push_back(c);
            req_wr_z    = 1'b0;
            req_wdata_z = $urandom;
         end
         if (rsp_valid_z) begin
            checkOutput("z_latency", c - last_acc, 1);
            checkOutput("z_rdata", rsp_rdata_z, (rsps == 0) ? 32'd0 : val);
            checkOutput("z_err", 32'(rsp_err_z), 0);
            rsps++;
         end
      end
      req_valid_z = 1'b0;
      checkOutput("z_accepts", accepts.size(), 5);
      checkOutput("z_rsps", rsps, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
